control_unit: RTL and testbench

Hardwired Moore control sequencer that drives the datapath's control inputs (PCout, MARin, IncPC, Read, MDRin, IRin, Gra/Grb/Grc, and the rest) that benches currently drive by hand. It sits directly upstream of `Datapath` and consumes only the instruction register value and the CON flip-flop output. It steps each instruction through the fetch states T0–T2 and opcode-specific execute states, then returns to T0. It also supports conditional branching, halt, and a graceful stop.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/instr_class_decode.sv | 33 +++
 rtl/control_unit.sv | 168 ++++++++++++++++
 tb/tb_control_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, sequencer states and instruction classes for control_unit
package cpu_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    // One-hot ALU select, bit order {ADD, SUB, AND, OR}
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0001;

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_RR  = 4'd0,
        CLS_ALU_IMM = 4'd1,
        CLS_LDI     = 4'd2,
        CLS_LD      = 4'd3,
        CLS_ST      = 4'd4,
        CLS_BR      = 4'd5,
        CLS_JR      = 4'd6,
        CLS_NOP     = 4'd7,
        CLS_HALT    = 4'd8
    } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// rtl/instr_class_decode.sv - opcode to instruction class and one-hot ALU select
module instr_class_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] op,
    output logic [3:0]     cls,
    output logic [3:0]     alu_sel
);

    always_comb begin
        cls     = CLS_NOP;
        alu_sel = ALU_NONE;
        case (op)
            OP_ADD:  begin cls = CLS_ALU_RR;  alu_sel = ALU_ADD; end
            OP_SUB:  begin cls = CLS_ALU_RR;  alu_sel = ALU_SUB; end
            OP_AND:  begin cls = CLS_ALU_RR;  alu_sel = ALU_AND; end
            OP_OR:   begin cls = CLS_ALU_RR;  alu_sel = ALU_OR;  end
            OP_ADDI: begin cls = CLS_ALU_IMM; alu_sel = ALU_ADD; end
            OP_ANDI: begin cls = CLS_ALU_IMM; alu_sel = ALU_AND; end
            OP_ORI:  begin cls = CLS_ALU_IMM; alu_sel = ALU_OR;  end
            OP_LDI:  cls = CLS_LDI;
            OP_LD:   cls = CLS_LD;
            OP_ST:   cls = CLS_ST;
            OP_BR:   cls = CLS_BR;
            OP_JR:   cls = CLS_JR;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore sequencer driving datapath control strobes
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        Write,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        CONin,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d, op_cur;
    logic           stop_q, stop_d;
    logic [3:0]     cls_raw;
    logic [3:0]     alu_sel;
    instr_class_t   cls;
    logic           goto_t0;
    logic           unused_ir;

    // IR only holds the new instruction from T3 onward, so T3 decodes it live
    assign op_cur    = (state_q == S_T3) ? IR[31 -: OPW] : op_q;
    assign cls       = instr_class_t'(cls_raw);
    assign unused_ir = ^IR[31-OPW:0];

    instr_class_decode #(.OPW(OPW)) u_decode (
        .op      (op_cur),
        .cls     (cls_raw),
        .alu_sel (alu_sel)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_T0;
            op_q    <= OP_NOP;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = (state_q == S_T3) ? op_cur : op_q;
        stop_d  = stop_q | Stop;
        goto_t0 = 1'b0;
        case (state_q)
            S_T0: state_d = S_T1;
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                case (cls)
                    CLS_JR, CLS_NOP: goto_t0 = 1'b1;
                    CLS_HALT:        state_d = S_HALT;
                    default:         state_d = S_T4;
                endcase
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls == CLS_ALU_RR || cls == CLS_ALU_IMM || cls == CLS_LDI) goto_t0 = 1'b1;
                else                                                           state_d = S_T6;
            end
            S_T6: begin
                if (cls == CLS_BR) goto_t0 = 1'b1;
                else               state_d = S_T7;
            end
            S_T7:    goto_t0 = 1'b1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_T0;
        endcase
        // A pending stop diverts the instruction boundary into HALT
        if (goto_t0) state_d = (stop_q | Stop) ? S_HALT : S_T0;
    end

    always_comb begin
        Run = 1'b0; PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0;
        Read = 1'b0; Write = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        CONin = 1'b0; ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
        if (!clr) begin
            Run = (state_q != S_HALT);
            case (state_q)
                S_T0: begin PCout = 1'b1; MARin = 1'b1; end
                S_T1: begin IncPC = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
                S_T3: begin
                    case (cls)
                        CLS_ALU_RR, CLS_ALU_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        CLS_LDI, CLS_LD, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                        CLS_BR:                  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                        CLS_JR:                  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T4: begin
                    case (cls)
                        CLS_ALU_RR: begin
                            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                            {ADD, SUB, AND, OR} = alu_sel;
                        end
                        CLS_ALU_IMM: begin
                            Cout = 1'b1; Zin = 1'b1;
                            {ADD, SUB, AND, OR} = alu_sel;
                        end
                        CLS_LDI, CLS_LD, CLS_ST: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                        CLS_BR:                  begin PCout = 1'b1; Yin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (cls)
                        CLS_ALU_RR, CLS_ALU_IMM, CLS_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CLS_LD, CLS_ST:                   begin Zlowout = 1'b1; MARin = 1'b1; end
                        CLS_BR:                           begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (cls)
                        CLS_LD:  begin Read = 1'b1; MDRin = 1'b1; end
                        CLS_ST:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                        CLS_BR:  begin Zlowout = 1'b1; PCin = CON; end
                        default: ;
                    endcase
                end
                S_T7: begin
                    case (cls)
                        CLS_LD:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CLS_ST:  Write = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed table plus randomized instruction stream for control_unit
module tb_control_unit;

    logic        clk, clr, CON, Stop;
    logic [31:0] IR;
    logic Run, PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, Zin, Zlowout, CONin;
    logic ADD, SUB, AND, OR;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .Write(Write), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .CONin(CONin),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] act;
    assign act = {Run, PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
                  Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, Zin, Zlowout, CONin,
                  ADD, SUB, AND, OR};

    localparam logic [24:0] M_OR = 25'b1 << 0,  M_AND = 25'b1 << 1,  M_SUB = 25'b1 << 2;
    localparam logic [24:0] M_ADD = 25'b1 << 3, M_CONIN = 25'b1 << 4, M_ZLO = 25'b1 << 5;
    localparam logic [24:0] M_ZIN = 25'b1 << 6, M_YIN = 25'b1 << 7,  M_COUT = 25'b1 << 8;
    localparam logic [24:0] M_BAOUT = 25'b1 << 9, M_ROUT = 25'b1 << 10, M_RIN = 25'b1 << 11;
    localparam logic [24:0] M_GRC = 25'b1 << 12, M_GRB = 25'b1 << 13, M_GRA = 25'b1 << 14;
    localparam logic [24:0] M_IRIN = 25'b1 << 15, M_MDROUT = 25'b1 << 16, M_MDRIN = 25'b1 << 17;
    localparam logic [24:0] M_WRITE = 25'b1 << 18, M_READ = 25'b1 << 19, M_PCIN = 25'b1 << 20;
    localparam logic [24:0] M_INCPC = 25'b1 << 21, M_MARIN = 25'b1 << 22, M_PCOUT = 25'b1 << 23;
    localparam logic [24:0] M_RUN = 25'b1 << 24;

    int n_checks = 0;
    int n_errors = 0;

    logic [24:0] exp_q[$];
    logic        model_stop;
    logic        model_halted;

    task automatic check(input string name, input logic [24:0] got, input logic [24:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    function automatic logic [24:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b01100: return M_ADD;
            5'b00100:           return M_SUB;
            5'b00101, 5'b01101: return M_AND;
            5'b00110, 5'b01110: return M_OR;
            default:            return 25'b0;
        endcase
    endfunction

    // Strobe list for one whole instruction, one entry per clock
    task automatic build_seq(input logic [4:0] op, input logic con);
        logic [24:0] addr2;
        exp_q.delete();
        exp_q.push_back(M_PCOUT | M_MARIN);
        exp_q.push_back(M_INCPC | M_READ | M_MDRIN);
        exp_q.push_back(M_MDROUT | M_IRIN);
        addr2 = M_COUT | M_ADD | M_ZIN;
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_GRC | M_ROUT | alu_of(op) | M_ZIN);
                exp_q.push_back(M_ZLO | M_GRA | M_RIN);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                exp_q.push_back(M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_COUT | alu_of(op) | M_ZIN);
                exp_q.push_back(M_ZLO | M_GRA | M_RIN);
            end
            5'b00001: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
                exp_q.push_back(addr2);
                exp_q.push_back(M_ZLO | M_GRA | M_RIN);
            end
            5'b00000, 5'b00010: begin
                exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
                exp_q.push_back(addr2);
                exp_q.push_back(M_ZLO | M_MARIN);
                if (op == 5'b00000) begin
                    exp_q.push_back(M_READ | M_MDRIN);
                    exp_q.push_back(M_MDROUT | M_GRA | M_RIN);
                end else begin
                    exp_q.push_back(M_GRA | M_ROUT | M_MDRIN);
                    exp_q.push_back(M_WRITE);
                end
            end
            5'b10010: begin
                exp_q.push_back(M_GRA | M_ROUT | M_CONIN);
                exp_q.push_back(M_PCOUT | M_YIN);
                exp_q.push_back(M_COUT | M_ADD | M_ZIN);
                exp_q.push_back(M_ZLO | (con ? M_PCIN : 25'b0));
            end
            5'b10100: exp_q.push_back(M_GRA | M_ROUT | M_PCIN);
            default:  exp_q.push_back(25'b0);
        endcase
    endtask

    task automatic do_reset();
        clr  = 1'b1;
        Stop = 1'b0;
        IR   = $urandom;
        @(negedge clk);
        check("reset_zero", act, 25'b0);
        @(posedge clk); #1;
        clr          = 1'b0;
        model_stop   = 1'b0;
        model_halted = 1'b0;
    endtask

    task automatic idle_halted();
        for (int i = 0; i < 2; i++) begin
            IR   = $urandom;
            CON  = 1'($urandom);
            Stop = 1'($urandom);
            @(negedge clk);
            check("halt_state", act, 25'b0);
            @(posedge clk); #1;
        end
        Stop = 1'b0;
    endtask

    // Runs one instruction from T0; abort_k pulses clr at that step instead
    task automatic exec(input logic [31:0] instr, input logic con, input int stop_k,
                        input int abort_k, input int probe_k, input logic [24:0] probe_mask);
        logic [4:0] op;
        op = instr[31:27];
        build_seq(op, con);
        for (int k = 0; k < exp_q.size(); k++) begin
            IR  = (k == 3) ? instr : $urandom;
            CON = (k == 6) ? con : 1'($urandom);
            if (k == abort_k) begin
                clr  = 1'b1;
                Stop = 1'b0;
                @(negedge clk);
                check("clr_mid", act, 25'b0);
                @(posedge clk); #1;
                clr          = 1'b0;
                model_stop   = 1'b0;
                model_halted = 1'b0;
                return;
            end
            Stop = (k == stop_k);
            if (Stop) model_stop = 1'b1;
            @(negedge clk);
            check("step", act, exp_q[k] | M_RUN);
            check("rw_excl", {24'b0, Read & Write}, 25'b0);
            check("alu_onehot", {24'b0, $countones(act[3:0]) > 1}, 25'b0);
            if (k == probe_k) check("probe", act, probe_mask);
            @(posedge clk); #1;
        end
        Stop = 1'b0;
        if (model_stop || op == 5'b11011) model_halted = 1'b1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        con;
        int          stop_k;
        int          probe_k;
        logic [24:0] probe_mask;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[16];

    logic [4:0] ops[14] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                            5'b01100, 5'b01101, 5'b01110, 5'b10010, 5'b10100, 5'b11010, 5'b11011};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h09000035, 1'b0, -1, 5, M_RUN | M_ZLO | M_GRA | M_RIN, 1'b0};
        vecs[1]  = '{32'h90800004, 1'b0, -1, 6, M_RUN | M_ZLO, 1'b0};
        vecs[2]  = '{32'h90800004, 1'b1, -1, 6, M_RUN | M_ZLO | M_PCIN, 1'b0};
        vecs[3]  = '{32'h00800010, 1'b0, -1, 6, M_RUN | M_READ | M_MDRIN, 1'b0};
        vecs[4]  = '{32'h10800010, 1'b0, -1, 7, M_RUN | M_WRITE, 1'b0};
        vecs[5]  = '{32'h20000000, 1'b0, -1, 4, M_RUN | M_GRC | M_ROUT | M_SUB | M_ZIN, 1'b0};
        vecs[6]  = '{32'h30000000, 1'b0, -1, 4, M_RUN | M_GRC | M_ROUT | M_OR | M_ZIN, 1'b0};
        vecs[7]  = '{32'h28000000, 1'b0, -1, 4, M_RUN | M_GRC | M_ROUT | M_AND | M_ZIN, 1'b0};
        vecs[8]  = '{32'h60000000, 1'b0, -1, 4, M_RUN | M_COUT | M_ADD | M_ZIN, 1'b0};
        vecs[9]  = '{32'h68000000, 1'b0, -1, 4, M_RUN | M_COUT | M_AND | M_ZIN, 1'b0};
        vecs[10] = '{32'h70000000, 1'b0, -1, 4, M_RUN | M_COUT | M_OR | M_ZIN, 1'b0};
        vecs[11] = '{32'hA0000000, 1'b0, -1, 3, M_RUN | M_GRA | M_ROUT | M_PCIN, 1'b0};
        vecs[12] = '{32'hD0000000, 1'b0, -1, 3, M_RUN, 1'b0};
        vecs[13] = '{32'hF8000000, 1'b0, -1, 3, M_RUN, 1'b0};
        vecs[14] = '{32'h18000000, 1'b0, 4, 5, M_RUN | M_ZLO | M_GRA | M_RIN, 1'b1};
        vecs[15] = '{32'hD8000000, 1'b0, -1, 3, M_RUN, 1'b1};

        clr = 1'b1; Stop = 1'b0; CON = 1'b0; IR = 32'h0;
        model_stop = 1'b0; model_halted = 1'b0;
        @(posedge clk); #1;
        do_reset();

        foreach (vecs[i]) begin
            exec(vecs[i].instr, vecs[i].con, vecs[i].stop_k, -1, vecs[i].probe_k, vecs[i].probe_mask);
            if (vecs[i].exp_halt) begin
                idle_halted();
                do_reset();
            end
        end

        // clr during HALT, then ld abandoned at T6 and a following add
        exec(32'hD8000000, 1'b0, -1, -1, -1, 25'b0);
        idle_halted();
        do_reset();
        exec(32'h00800010, 1'b0, -1, 6, -1, 25'b0);
        exec(32'h18000000, 1'b0, -1, -1, 5, M_RUN | M_ZLO | M_GRA | M_RIN);
        // Stop raised only on the final step still diverts to HALT
        exec(32'h18000000, 1'b0, 5, -1, -1, 25'b0);
        idle_halted();
        do_reset();
        // Stop during T0 of jr
        exec(32'hA0000000, 1'b0, 0, -1, -1, 25'b0);
        idle_halted();
        do_reset();

        for (int n = 0; n < 150; n++) begin
            logic [4:0]  op;
            logic [31:0] instr;
            int          stop_k, abort_k;
            op      = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 13)];
            instr   = {op, 27'($urandom)};
            stop_k  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : -1;
            abort_k = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 7)) : -1;
            exec(instr, 1'($urandom), stop_k, abort_k, -1, 25'b0);
            if (model_halted) begin
                idle_halted();
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
